// File: rtl/synapse_sweep_ctrl.sv
// synapse_sweep_ctrl: sweep sequencer and host-port arbiter for the synapse RAMs.
// Walks every slot with one read cycle followed by one write-back cycle, flags
// the initialising first sweep, and lets a host read/write one word between sweeps.
module synapse_sweep_ctrl #(
    parameter int N_SYN = 128,
    parameter int AW    = 7,
    parameter int DW    = 32,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic          phase,
    output logic          host_sel,
    output logic          first_pass,
    output logic          sweep_done,
    output logic [CW-1:0] sweep_count,
    output logic          busy,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] host_rdata,
    output logic          host_ack
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_HA   = 3'd3;
    localparam logic [2:0] S_HD   = 3'd4;

    localparam logic [AW-1:0] LAST_SLOT = AW'(N_SYN - 1);

    logic [2:0]    state_reg;
    logic          hwe_reg;       // host_we latched at grant
    logic          ack_seen_reg;  // blocks re-grant until host_req has dropped
    logic [DW-1:0] rdata_reg;     // last word read by the host

    // Main sequencer: state plus all registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            phase       <= 1'b0;
            host_sel    <= 1'b0;
            first_pass  <= 1'b1;
            sweep_done  <= 1'b0;
            sweep_count <= '0;
            busy        <= 1'b0;
            host_ack    <= 1'b0;
            hwe_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            sweep_done <= 1'b0;
            host_ack   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // Host wins over run; a request already acknowledged is ignored.
                    if (host_req && !ack_seen_reg) begin
                        state_reg <= S_HA;
                        ram_addr  <= host_addr;
                        ram_we    <= host_we;
                        hwe_reg   <= host_we;
                        host_sel  <= 1'b1;
                        phase     <= 1'b0;
                        busy      <= 1'b1;
                    end else if (run) begin
                        state_reg <= S_RD;
                        ram_addr  <= '0;
                        ram_we    <= 1'b0;
                        phase     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_RD: begin
                    state_reg  <= S_WR;
                    ram_we     <= 1'b1;
                    phase      <= 1'b1;
                    // Pulse lines up with the write cycle of the final slot.
                    sweep_done <= (ram_addr == LAST_SLOT);
                end
                S_WR: begin
                    ram_we <= 1'b0;
                    phase  <= 1'b0;
                    if (ram_addr == LAST_SLOT) begin
                        state_reg   <= S_IDLE;
                        ram_addr    <= '0;
                        busy        <= 1'b0;
                        sweep_count <= sweep_count + 1'b1;
                        first_pass  <= 1'b0;
                    end else begin
                        state_reg <= S_RD;
                        ram_addr  <= ram_addr + 1'b1;
                    end
                end
                S_HA: begin
                    state_reg <= S_HD;
                    host_sel  <= 1'b0;
                    ram_we    <= 1'b0;
                    host_ack  <= 1'b1;
                end
                S_HD: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    if (!hwe_reg) begin
                        rdata_reg <= ram_rdata;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    ram_we    <= 1'b0;
                    host_sel  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Acknowledge memory: set by a completed host access, cleared once host_req falls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_seen_reg <= 1'b0;
        end else if (state_reg == S_HD) begin
            ack_seen_reg <= 1'b1;
        end else if (!host_req) begin
            ack_seen_reg <= 1'b0;
        end
    end

    // The RAM word for a host read only arrives during HD, so it is forwarded
    // directly in that cycle to make host_rdata valid together with host_ack.
    assign host_rdata = (state_reg == S_HD && !hwe_reg) ? ram_rdata : rdata_reg;

endmodule

// File: tb/tb_synapse_sweep_ctrl.sv
// tb_synapse_sweep_ctrl: randomized host/run stimulus against a slot-counting
// reference model of the sweep schedule and host handshake.
module tb_synapse_sweep_ctrl;

    localparam int N_SYN = 128;
    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int OW    = AW + 7;
    localparam int SWEEP = 2 * N_SYN;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          phase;
    logic          host_sel;
    logic          first_pass;
    logic          sweep_done;
    logic [CW-1:0] sweep_count;
    logic          busy;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] host_rdata;
    logic          host_ack;

    always #5 clk = ~clk;

    synapse_sweep_ctrl #(.N_SYN(N_SYN), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .run(run),
        .ram_addr(ram_addr), .ram_we(ram_we), .phase(phase), .host_sel(host_sel),
        .first_pass(first_pass), .sweep_done(sweep_done), .sweep_count(sweep_count),
        .busy(busy), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .ram_rdata(ram_rdata), .host_rdata(host_rdata), .host_ack(host_ack)
    );

    // Registered-read RAM with fixed random contents.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: m_pos counts cycles into a sweep (0 = not sweeping),
    // m_host counts the two host cycles (1 = address, 2 = data/ack).
    int            m_pos, m_host, cyc, req_cyc, hold_left;
    logic [AW-1:0] m_haddr;
    logic          m_hwe, m_first, m_hold, acked;
    logic [CW-1:0] m_count;
    logic [DW-1:0] m_rdata;

    task automatic model_reset();
        m_pos = 0; m_host = 0; m_haddr = '0; m_hwe = 1'b0;
        m_first = 1'b1; m_hold = 1'b0; m_count = '0; m_rdata = '0;
    endtask

    function automatic logic exp_ack();
        return (m_pos == 0 && m_host == 2);
    endfunction

    task automatic model_step();
        logic nh;
        nh = (m_pos == 0 && m_host == 2) ? 1'b1 : (host_req ? m_hold : 1'b0);
        if (m_pos > 0) begin
            if (m_pos == SWEEP) begin
                m_pos = 0; m_count++; m_first = 1'b0;
                $display("sweep %0d complete at cycle %0d", m_count, cyc);
            end else begin
                m_pos++;
            end
        end else if (m_host == 1) begin
            m_host = 2;
        end else if (m_host == 2) begin
            m_host = 0;
            if (!m_hwe) m_rdata = mem[m_haddr];
            $display("host %s addr=%0d rdata=%0h at cycle %0d", m_hwe ? "write" : "read", m_haddr, m_rdata, cyc);
        end else if (host_req && !m_hold) begin
            m_host = 1; m_haddr = host_addr; m_hwe = host_we;
        end else if (run) begin
            m_pos = 1;
        end
        m_hold = nh;
    endtask

    task automatic compare();
        logic [OW-1:0] o, e, msk;
        logic [OW-1:0] addr_bits, phase_bit;
        logic [DW-1:0] erd;
        addr_bits = {{AW{1'b1}}, 7'b0000000};
        phase_bit = {{AW{1'b0}}, 7'b0100000};
        o   = {ram_addr, ram_we, phase, host_sel, first_pass, sweep_done, busy, host_ack};
        msk = '1;
        if (m_pos > 0) begin
            e = {AW'((m_pos - 1) / 2), (m_pos % 2 == 0), (m_pos % 2 == 0), 1'b0,
                 m_first, (m_pos == SWEEP), 1'b1, 1'b0};
        end else if (m_host == 1) begin
            e   = {m_haddr, m_hwe, 1'b0, 1'b1, m_first, 1'b0, 1'b1, 1'b0};
            msk = ~phase_bit;
        end else if (m_host == 2) begin
            e   = {{AW{1'b0}}, 1'b0, 1'b0, 1'b0, m_first, 1'b0, 1'b1, 1'b1};
            msk = ~(phase_bit | addr_bits);
        end else begin
            e   = {{AW{1'b0}}, 1'b0, 1'b0, 1'b0, m_first, 1'b0, 1'b0, 1'b0};
            msk = ~(phase_bit | addr_bits);
        end
        check($sformatf("ctl@%0d", cyc), 64'(o & msk), 64'(e & msk));
        check($sformatf("count@%0d", cyc), 64'(sweep_count), 64'(m_count));
        erd = (m_pos == 0 && m_host == 2 && !m_hwe) ? mem[m_haddr] : m_rdata;
        check($sformatf("rdata@%0d", cyc), 64'(host_rdata), 64'(erd));
        // Latency bound from request to acknowledge.
        if (host_ack === 1'b1 && host_req && !acked)
            check("ack_lat", 64'((cyc - req_cyc) <= SWEEP + 3), 64'(1));
    endtask

    // Host protocol driver: raise, hold until ack plus 0..10 cycles, drop.
    task automatic drive_random(input bit allow_new, input bit run_rand);
        if (run_rand && $urandom_range(0, 199) == 0) run = ~run;
        if (!host_req) begin
            if (allow_new && $urandom_range(0, 39) == 0) begin
                host_req  = 1'b1;
                host_we   = 1'($urandom_range(0, 1));
                host_addr = AW'($urandom);
                req_cyc   = cyc;
                acked     = 1'b0;
            end
        end else if (exp_ack()) begin
            acked     = 1'b1;
            hold_left = $urandom_range(0, 10);
            if (hold_left == 0) host_req = 1'b0;
        end else if (acked) begin
            hold_left--;
            if (hold_left <= 0) host_req = 1'b0;
        end
    endtask

    initial begin
        bit b_done, rst_done;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        reset = 1'b1; run = 1'b0; host_req = 1'b0; host_we = 1'b0; host_addr = '0;
        acked = 1'b0; hold_left = 0; req_cyc = 0; cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);

        // Reset values.
        @(negedge clk);
        compare();
        check("rst_addr", 64'(ram_addr), 64'(0));
        check("rst_phase", 64'(phase), 64'(0));
        reset = 1'b0; run = 1'b1;
        model_step();

        // Three back-to-back sweeps with run held high.
        for (int k = 1; k <= 3 * (SWEEP + 1); k++) begin
            @(negedge clk); cyc = k;
            compare();
            if (k == SWEEP) begin
                check("done_at_2N", 64'(sweep_done), 64'(1));
                check("first_last_wr", 64'(first_pass), 64'(1));
            end
            if (k == SWEEP + 1) begin
                check("first_cleared", 64'(first_pass), 64'(0));
                check("count_1", 64'(sweep_count), 64'(1));
                check("idle_gap", 64'(busy), 64'(0));
            end
            if (k == SWEEP + 2) check("rd2_start", 64'({busy, ram_addr, ram_we}), 64'({1'b1, {AW{1'b0}}, 1'b0}));
            if (k == 3 * (SWEEP + 1)) check("count_3", 64'(sweep_count), 64'(3));
            model_step();
        end

        // Host read of slot 5 issued during slot 40.
        b_done = 1'b0;
        for (int k = 0; k < SWEEP + 20; k++) begin
            @(negedge clk); cyc++;
            compare();
            if (exp_ack() && host_req) begin
                check("slot5_rdata", 64'(host_rdata), 64'(mem[5]));
                host_req = 1'b0;
            end else if (m_pos == 81 && !b_done) begin
                host_req = 1'b1; host_we = 1'b0; host_addr = AW'(5);
                req_cyc = cyc; acked = 1'b0; b_done = 1'b1;
            end
            model_step();
        end

        // Randomized run level and host traffic.
        for (int k = 0; k < 12000; k++) begin
            @(negedge clk); cyc++;
            compare();
            drive_random(1'b1, 1'b1);
            model_step();
        end

        // Drain host traffic, then reset during the write cycle of slot 30.
        run = 1'b1; rst_done = 1'b0;
        for (int k = 0; k < 4 * (SWEEP + 5) && !rst_done; k++) begin
            @(negedge clk); cyc++;
            compare();
            if (m_pos == 62 && !host_req) begin
                check("pre_rst_we", 64'(ram_we), 64'(1));
                reset = 1'b1;
                #1;
                check("rst_we_async", 64'(ram_we), 64'(0));
                check("rst_busy", 64'(busy), 64'(0));
                check("rst_first", 64'(first_pass), 64'(1));
                check("rst_count", 64'(sweep_count), 64'(0));
                check("rst_addr2", 64'(ram_addr), 64'(0));
                model_reset();
                rst_done = 1'b1;
            end else begin
                drive_random(1'b0, 1'b0);
                model_step();
            end
        end
        check("rst_reach", 64'(rst_done), 64'(1));

        // Restart from slot 0 with first_pass set again.
        @(negedge clk); cyc++;
        compare();
        reset = 1'b0; run = 1'b1; host_req = 1'b0;
        model_step();
        for (int k = 1; k <= 2 * (SWEEP + 1) + 10; k++) begin
            @(negedge clk); cyc++;
            compare();
            if (k == 1) check("restart_slot0", 64'({busy, ram_addr}), 64'({1'b1, {AW{1'b0}}}));
            if (k == SWEEP) check("restart_first", 64'(first_pass), 64'(1));
            if (k == SWEEP + 1) check("restart_first_clr", 64'(first_pass), 64'(0));
            model_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
